// File: rtl/perm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : perm_pkg
// Brief    : Shared types, widths and count-extraction helper for the
//            quadword shift/rotate permute pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package perm_pkg;

  localparam int QW              = 128; // quadword width
  localparam int OP_W            = 4;   // op select width
  localparam int IMM_W           = 7;   // I7 immediate width
  localparam int CNT_SEL_W       = 5;   // widest extracted count
  localparam int BYTE_SHIFT_ZERO = 16;  // byte-shift counts at or above this give zero

  typedef enum logic [OP_W-1:0] {
    OP_SHLQBY   = 4'd0,
    OP_SHLQBYI  = 4'd1,
    OP_ROTQBY   = 4'd2,
    OP_ROTQBYI  = 4'd3,
    OP_SHLQBI   = 4'd4,
    OP_ROTQBI   = 4'd5,
    OP_SHLQBYBI = 4'd6,
    OP_ROTQBYBI = 4'd7
  } perm_op_e;

  // rb_lo carries rb[24:31] (rb_lo[0] == rb[24]); imm_lo carries imm[2:6].
  // Narrower counts are zero-extended so the shift unit sees one 5-bit count.
  function automatic logic [CNT_SEL_W-1:0] perm_count(
    input logic [OP_W-1:0] op,
    input logic [0:7]      rb_lo,
    input logic [0:4]      imm_lo
  );
    logic [CNT_SEL_W-1:0] cnt;
    cnt = '0;
    case (op)
      OP_SHLQBY:   cnt = rb_lo[3:7];
      OP_SHLQBYI:  cnt = imm_lo;
      OP_ROTQBY:   cnt = {1'b0, rb_lo[4:7]};
      OP_ROTQBYI:  cnt = {1'b0, imm_lo[1:4]};
      OP_SHLQBI,
      OP_ROTQBI:   cnt = {2'b00, rb_lo[5:7]};
      OP_SHLQBYBI: cnt = rb_lo[0:4];
      OP_ROTQBYBI: cnt = {1'b0, rb_lo[1:4]};
      default:     cnt = '0;
    endcase
    return cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/perm_shift_unit.sv
`default_nettype none
// ============================================================================
// Module   : perm_shift_unit
// Brief    : Combinational quadword byte/bit shift and rotate. Big-endian
//            numbering: shifting toward bit 0 is a left shift of [0:127].
// Revision : 1.0 - initial release
// ============================================================================
module perm_shift_unit
  import perm_pkg::*;
(
  input  logic [0:QW-1]        ra,
  input  logic [CNT_SEL_W-1:0] count,
  input  logic [OP_W-1:0]      op,
  output logic [0:QW-1]        result
);

  logic [7:0] w_byte_amt;
  logic [7:0] w_bit_amt;

  assign w_byte_amt = {1'b0, count[3:0], 3'b000};
  assign w_bit_amt  = {5'b00000, count[2:0]};

  // Select the shift/rotate form; illegal ops yield zero data.
  // A zero rotate amount shifts the wrap term out by 128, leaving ra intact.
  always_comb begin
    result = '0;
    case (op)
      OP_SHLQBY, OP_SHLQBYI, OP_SHLQBYBI:
        result = (count >= CNT_SEL_W'(BYTE_SHIFT_ZERO)) ? '0 : (ra << w_byte_amt);
      OP_ROTQBY, OP_ROTQBYI, OP_ROTQBYBI:
        result = (ra << w_byte_amt) | (ra >> (8'd128 - w_byte_amt));
      OP_SHLQBI:
        result = ra << w_bit_amt;
      OP_ROTQBI:
        result = (ra << w_bit_amt) | (ra >> (8'd128 - w_bit_amt));
      default:
        result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/perm_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : perm_pipe_ctrl
// Brief    : Issue acceptance, fixed-depth result pipeline with stall/flush,
//            per-stage target export and retire/stall counters for the
//            quadword shift/rotate instructions.
// Revision : 1.0 - initial release
// ============================================================================
module perm_pipe_ctrl
  import perm_pkg::*;
#(
  parameter int LAT   = 4,
  parameter int RT_W  = 7,
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [OP_W-1:0]     issue_op,
  input  logic [RT_W-1:0]     issue_rt,
  input  logic [0:QW-1]       issue_ra,
  input  logic [0:QW-1]       issue_rb,
  input  logic [0:IMM_W-1]    issue_imm,
  input  logic                flush,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [RT_W-1:0]     wb_rt,
  output logic [0:QW-1]       wb_data,
  output logic [LAT-1:0]      stg_valid,
  output logic [LAT*RT_W-1:0] stg_rt,
  output logic                illegal_op,
  output logic [CNT_W-1:0]    retire_cnt,
  output logic [CNT_W-1:0]    stall_cnt
);

  logic [LAT-1:0]       r_valid;
  logic [RT_W-1:0]      r_rt   [LAT];
  logic [0:QW-1]        r_data [LAT];
  logic                 r_illegal;
  logic [CNT_W-1:0]     r_retire_cnt;
  logic [CNT_W-1:0]     r_stall_cnt;

  logic                 w_stall;
  logic                 w_accept;
  logic [CNT_SEL_W-1:0] w_count;
  logic [0:QW-1]        w_result;
  logic                 w_unused_bits;

  assign w_stall     = r_valid[LAT-1] & ~wb_ready;
  assign issue_ready = ~w_stall & ~flush;
  assign w_accept    = issue_valid & issue_ready;

  // Only rb[24:31] and imm[2:6] ever feed a count.
  assign w_count       = perm_count(issue_op, issue_rb[24:31], issue_imm[2:6]);
  assign w_unused_bits = ^{issue_rb[0:23], issue_rb[32:127], issue_imm[0:1]};

  perm_shift_unit u_shift (
    .ra     (issue_ra),
    .count  (w_count),
    .op     (issue_op),
    .result (w_result)
  );

  // Pipeline advance: flush kills everything, stall freezes every stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_rt[i]   <= '0;
        r_data[i] <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
    end else if (!w_stall) begin
      r_valid <= {r_valid[LAT-2:0], w_accept};
      if (w_accept) begin
        r_rt[0]   <= issue_rt;
        r_data[0] <= w_result;
      end
      for (int i = 1; i < LAT; i++) begin
        r_rt[i]   <= r_rt[i-1];
        r_data[i] <= r_data[i-1];
      end
    end
  end

  // Sticky illegal-op flag; op codes 8..15 all have bit 3 set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_illegal <= 1'b0;
    else if (w_accept && issue_op[3]) r_illegal <= 1'b1;
  end

  // Retire and stall counters; a flush cycle counts as neither.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retire_cnt <= '0;
      r_stall_cnt  <= '0;
    end else if (!flush) begin
      if (r_valid[LAT-1] && wb_ready) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      if (w_stall)                    r_stall_cnt  <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign wb_valid   = r_valid[LAT-1];
  assign wb_rt      = r_rt[LAT-1];
  assign wb_data    = r_data[LAT-1];
  assign stg_valid  = r_valid;
  assign illegal_op = r_illegal;
  assign retire_cnt = r_retire_cnt;
  assign stall_cnt  = r_stall_cnt;

  for (genvar g = 0; g < LAT; g++) begin : g_stg_rt
    assign stg_rt[g*RT_W +: RT_W] = r_rt[g];
  end

endmodule
`default_nettype wire

// File: tb/tb_perm_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_perm_pipe_ctrl
// Brief    : Directed self-checking bench for perm_pipe_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_perm_pipe_ctrl;
  import perm_pkg::*;

  localparam int LAT   = 4;
  localparam int RT_W  = 7;
  localparam int CNT_W = 32;
  localparam logic [0:127] PAT = 128'h00112233445566778899AABBCCDDEEFF;

  logic                clk = 1'b0;
  logic                rst;
  logic                issue_valid;
  logic                issue_ready;
  logic [3:0]          issue_op;
  logic [RT_W-1:0]     issue_rt;
  logic [0:127]        issue_ra;
  logic [0:127]        issue_rb;
  logic [0:6]          issue_imm;
  logic                flush;
  logic                wb_valid;
  logic                wb_ready;
  logic [RT_W-1:0]     wb_rt;
  logic [0:127]        wb_data;
  logic [LAT-1:0]      stg_valid;
  logic [LAT*RT_W-1:0] stg_rt;
  logic                illegal_op;
  logic [CNT_W-1:0]    retire_cnt;
  logic [CNT_W-1:0]    stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]   op;
    logic [0:127] ra;
    logic [0:127] rb;
    logic [0:6]   imm;
    logic [0:127] exp;
  } vec_t;
  vec_t vecs[10];

  perm_pipe_ctrl #(.LAT(LAT), .RT_W(RT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_rt(issue_rt), .issue_ra(issue_ra), .issue_rb(issue_rb), .issue_imm(issue_imm),
    .flush(flush), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rt(wb_rt),
    .wb_data(wb_data), .stg_valid(stg_valid), .stg_rt(stg_rt), .illegal_op(illegal_op),
    .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [RT_W-1:0] rt,
                       input logic [0:127] ra, input logic [0:127] rb, input logic [0:6] imm);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_rt    = rt;
    issue_ra    = ra;
    issue_rb    = rb;
    issue_imm   = imm;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; wb_ready = 1'b1;
    drive(4'd0, '0, '0, '0, '0);
    issue_valid = 1'b0;
    tick(); tick();
    n_checks++; if (stg_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_stg_valid got %b exp 0000", stg_valid); end
    n_checks++; if (stg_rt !== '0) begin n_fail++; $display("FAIL reset_stg_rt got %h exp 0", stg_rt); end
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
    n_checks++; if (wb_data !== '0 || wb_rt !== '0) begin n_fail++; $display("FAIL reset_wb got data %h rt %h exp 0", wb_data, wb_rt); end
    n_checks++; if (illegal_op !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %b exp 0", illegal_op); end
    n_checks++; if (retire_cnt !== 0 || stall_cnt !== 0) begin n_fail++; $display("FAIL reset_counters got %0d/%0d exp 0/0", retire_cnt, stall_cnt); end
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready got %b exp 1", issue_ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_shlqby();
    logic [0:127] rb;
    rb = '0; rb[27:31] = 5'd3;
    drive(4'd0, 7'd5, PAT, rb, '0);
    tick();
    issue_valid = 1'b0;
    n_checks++; if (stg_valid !== 4'b0001 || stg_rt[RT_W-1:0] !== 7'd5) begin n_fail++; $display("FAIL basic_stage0 got %b/%h exp 0001/05", stg_valid, stg_rt[RT_W-1:0]); end
    tick(); tick();
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_wb got %b exp 0", wb_valid); end
    tick();
    n_checks++; if (wb_valid !== 1'b1 || wb_rt !== 7'd5) begin n_fail++; $display("FAIL basic_wb got v%b rt %h exp v1 rt 05", wb_valid, wb_rt); end
    n_checks++; if (wb_data !== 128'h33445566778899AABBCCDDEEFF000000) begin n_fail++; $display("FAIL basic_data got %h exp 33445566778899aabbccddeeff000000", wb_data); end
    n_checks++; if (stg_rt[3*RT_W +: RT_W] !== 7'd5) begin n_fail++; $display("FAIL basic_stg3_rt got %h exp 05", stg_rt[3*RT_W +: RT_W]); end
    tick();
    n_checks++; if (retire_cnt !== 1 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL basic_retire got %0d v%b exp 1 v0", retire_cnt, wb_valid); end
  endtask

  task automatic test_shift_forms();
    logic [0:127] rb;
    rb = '0; rb[27:31] = 5'd16;  vecs[0] = '{4'd0, PAT, rb, 7'd0, 128'h0};
    rb = '0; rb[27:31] = 5'd15;  vecs[1] = '{4'd0, PAT, rb, 7'd0, {8'hFF, 120'h0}};
    rb = '0;                     vecs[2] = '{4'd3, PAT, rb, 7'h11, 128'h112233445566778899AABBCCDDEEFF00};
    rb = '0; rb[29:31] = 3'd1;   vecs[3] = '{4'd4, 128'h80000000000000000000000000000001, rb, 7'd0, 128'h2};
                                 vecs[4] = '{4'd5, 128'h80000000000000000000000000000001, rb, 7'd0, 128'h3};
    rb = '0; rb[24:28] = 5'd2;   vecs[5] = '{4'd6, PAT, rb, 7'd0, 128'h2233445566778899AABBCCDDEEFF0000};
    rb = '0; rb[27:31] = 5'h1F;  vecs[6] = '{4'd2, PAT, rb, 7'd0, 128'hFF00112233445566778899AABBCCDDEE};
    rb = '0;                     vecs[7] = '{4'd1, PAT, rb, 7'b1100000, PAT};
    rb = '0; rb[25:28] = 4'd3;   vecs[8] = '{4'd7, PAT, rb, 7'd0, 128'h33445566778899AABBCCDDEEFF001122};
    rb = '0;                     vecs[9] = '{4'd1, PAT, rb, 7'd20, 128'h0};
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].op, 7'(10 + i), vecs[i].ra, vecs[i].rb, vecs[i].imm);
      tick();
      issue_valid = 1'b0;
      tick(); tick(); tick();
      n_checks++; if (wb_valid !== 1'b1 || wb_rt !== 7'(10 + i)) begin n_fail++; $display("FAIL form%0d_wb got v%b rt %h exp v1 rt %h", i, wb_valid, wb_rt, 7'(10 + i)); end
      n_checks++; if (wb_data !== vecs[i].exp) begin n_fail++; $display("FAIL form%0d_data got %h exp %h", i, wb_data, vecs[i].exp); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [CNT_W-1:0] base;
    int j;
    base = retire_cnt;
    for (int k = 0; k < 12; k++) begin
      if (k < 8) drive(4'd0, 7'(20 + k), {120'h0, 8'(k + 1)}, '0, '0);
      else       issue_valid = 1'b0;
      tick();
      j = k - 3;
      if (j >= 0 && j < 8) begin
        n_checks++; if (wb_valid !== 1'b1 || wb_rt !== 7'(20 + j) || wb_data !== {120'h0, 8'(j + 1)}) begin
          n_fail++; $display("FAIL b2b_cyc%0d got v%b rt %h data %h exp v1 rt %h data %h", k, wb_valid, wb_rt, wb_data, 7'(20 + j), {120'h0, 8'(j + 1)});
        end
      end else begin
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_cyc%0d_idle got v%b exp v0", k, wb_valid); end
      end
    end
    n_checks++; if (retire_cnt - base !== 8) begin n_fail++; $display("FAIL b2b_retire got %0d exp 8", retire_cnt - base); end
  endtask

  task automatic test_stall();
    logic [CNT_W-1:0] base_stall, base_ret;
    base_ret = retire_cnt;
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(4'd0, 7'(40 + i), {120'h0, 8'(8'h40 + i)}, '0, '0);
      tick();
    end
    issue_valid = 1'b0;
    base_stall = stall_cnt;
    n_checks++; if (issue_ready !== 1'b0 || stg_valid !== 4'b1111) begin n_fail++; $display("FAIL stall_ready got rdy %b stg %b exp 0/1111", issue_ready, stg_valid); end
    drive(4'd0, 7'd99, PAT, '0, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (wb_valid !== 1'b1 || wb_rt !== 7'd40 || wb_data !== {120'h0, 8'h40} || stg_valid !== 4'b1111) begin
        n_fail++; $display("FAIL stall_hold%0d got v%b rt %h data %h stg %b exp v1 rt 28 data 40 stg 1111", i, wb_valid, wb_rt, wb_data, stg_valid);
      end
    end
    n_checks++; if (stall_cnt - base_stall !== 3) begin n_fail++; $display("FAIL stall_cnt got %0d exp 3", stall_cnt - base_stall); end
    issue_valid = 1'b0;
    wb_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      n_checks++; if (wb_valid !== 1'b1 || wb_rt !== 7'(40 + j) || wb_data !== {120'h0, 8'(8'h40 + j)}) begin
        n_fail++; $display("FAIL stall_drain%0d got v%b rt %h exp v1 rt %h", j, wb_valid, wb_rt, 7'(40 + j));
      end
      tick();
    end
    n_checks++; if (wb_valid !== 1'b0 || stg_valid !== 4'b0000) begin n_fail++; $display("FAIL stall_empty got v%b stg %b exp v0 stg 0000", wb_valid, stg_valid); end
    n_checks++; if (retire_cnt - base_ret !== 4 || stall_cnt - base_stall !== 3) begin n_fail++; $display("FAIL stall_counts got ret %0d stall %0d exp 4/3", retire_cnt - base_ret, stall_cnt - base_stall); end
  endtask

  task automatic test_flush();
    logic [CNT_W-1:0] base_ret;
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(4'd0, 7'(50 + i), PAT, '0, '0);
      tick();
    end
    issue_valid = 1'b0;
    n_checks++; if (stg_valid !== 4'b1111 || wb_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre got stg %b v%b exp 1111 v1", stg_valid, wb_valid); end
    base_ret = retire_cnt;
    flush = 1'b1;
    drive(4'd0, 7'd77, PAT, '0, '0);
    #1;
    n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b exp 0", issue_ready); end
    tick();
    flush = 1'b0;
    issue_valid = 1'b0;
    n_checks++; if (stg_valid !== 4'b0000 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_clear got stg %b v%b exp 0000 v0", stg_valid, wb_valid); end
    n_checks++; if (retire_cnt !== base_ret) begin n_fail++; $display("FAIL flush_retire got %0d exp %0d", retire_cnt, base_ret); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (wb_valid !== 1'b0 || stg_valid !== 4'b0000) begin n_fail++; $display("FAIL flush_after%0d got v%b stg %b exp v0 0000", i, wb_valid, stg_valid); end
    end
  endtask

  task automatic test_illegal();
    n_checks++; if (illegal_op !== 1'b0) begin n_fail++; $display("FAIL illegal_pre got %b exp 0", illegal_op); end
    drive(4'd9, 7'd9, PAT, '1, 7'h7F);
    tick();
    issue_valid = 1'b0;
    n_checks++; if (illegal_op !== 1'b1) begin n_fail++; $display("FAIL illegal_set got %b exp 1", illegal_op); end
    tick(); tick(); tick();
    n_checks++; if (wb_valid !== 1'b1 || wb_rt !== 7'd9 || wb_data !== '0) begin n_fail++; $display("FAIL illegal_wb got v%b rt %h data %h exp v1 rt 09 data 0", wb_valid, wb_rt, wb_data); end
    tick();
    drive(4'd0, 7'd3, PAT, '0, '0);
    tick();
    issue_valid = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (wb_data !== PAT || illegal_op !== 1'b1) begin n_fail++; $display("FAIL illegal_sticky got data %h ill %b exp %h ill 1", wb_data, illegal_op, PAT); end
    tick();
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 4; i++) begin
      drive(4'd0, 7'(60 + i), PAT, '0, '0);
      tick();
    end
    n_checks++; if (wb_valid !== 1'b1 || wb_data !== PAT) begin n_fail++; $display("FAIL rstmid_pre got v%b data %h exp v1 %h", wb_valid, wb_data, PAT); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (stg_valid !== 4'b0000 || wb_valid !== 1'b0 || stg_rt !== '0) begin n_fail++; $display("FAIL rstmid_valid got stg %b v%b rt %h exp 0", stg_valid, wb_valid, stg_rt); end
    n_checks++; if (wb_data !== '0 || wb_rt !== '0) begin n_fail++; $display("FAIL rstmid_wb got data %h rt %h exp 0", wb_data, wb_rt); end
    n_checks++; if (retire_cnt !== 0 || stall_cnt !== 0 || illegal_op !== 1'b0) begin n_fail++; $display("FAIL rstmid_state got ret %0d stall %0d ill %b exp 0/0/0", retire_cnt, stall_cnt, illegal_op); end
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b exp 1", issue_ready); end
    issue_valid = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_after%0d got v%b exp v0", i, wb_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_shlqby();
    test_shift_forms();
    test_back_to_back();
    test_stall();
    test_flush();
    test_illegal();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
